// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and width helper for the FIFO family.
package fifo_pkg;
  localparam int DEF_W = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, one write port and one registered read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_q;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end
  assign o_rdata = r_q;
endmodule

// File: rtl/async_fifo_core.sv
// async_fifo_core: single-clock FIFO with registered read data and full/afull/empty/aempty flags.
module async_fifo_core
  import fifo_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  output logic         afull,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         aempty
);
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_zero;
  logic          w_wr_acc, w_rd_acc;
  logic [W-1:0]  w_q;
  assign full     = r_count == (AW+1)'(DEPTH);
  assign afull    = r_count >= (AW+1)'(DEPTH-1);
  assign empty    = r_count == '0;
  assign aempty   = r_count <= (AW+1)'(1);
  assign w_wr_acc = wr_en & ~full & ~reset;
  assign w_rd_acc = rd_en & ~empty & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_zero  <= 1'b1;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      if (w_rd_acc) r_zero <= 1'b0;
      r_count <= r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);
    end
  end
  // RAM has no reset, so the reset value of rd_data is masked in until the first real read
  assign rd_data = r_zero ? '0 : w_q;
  fifo_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr),
    .i_wdata (wr_data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr),
    .o_rdata (w_q)
  );
endmodule

// File: tb/tb_async_fifo_core.sv
// tb_async_fifo_core: directed table-driven check of async_fifo_core (W=8, DEPTH=16).
module tb_async_fifo_core;
  typedef struct {
    logic       rst;
    logic       we;
    logic       re;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic [3:0] exp_fl;
  } vec_t;
  logic       clk = 0;
  logic       reset = 0;
  logic       wr_en = 0;
  logic       rd_en = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] rd_data;
  logic       full, afull, empty, aempty;
  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  async_fifo_core #(.W(8), .DEPTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .afull   (afull),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .aempty  (aempty)
  );
  function automatic void add(input logic rst, input logic we, input logic re,
                              input logic [7:0] wd, input logic [7:0] exp_rd, input logic [3:0] exp_fl);
    vec_t v;
    v.rst = rst; v.we = we; v.re = re; v.wd = wd; v.exp_rd = exp_rd; v.exp_fl = exp_fl;
    tbl.push_back(v);
  endfunction
  task automatic check(input string name, input logic [7:0] act_rd, input logic [7:0] exp_rd,
                       input logic [3:0] act_fl, input logic [3:0] exp_fl);
    n_vec++;
    if (act_rd !== exp_rd || act_fl !== exp_fl) begin
      n_bad++;
      $display("FAIL %s: rd_data=%h flags(full,afull,empty,aempty)=%b, expected rd_data=%h flags=%b",
               name, act_rd, act_fl, exp_rd, exp_fl);
    end
  endtask
  initial begin
    // reset with both requests high: empty, no write
    for (int i = 0; i < 3; i++) add(1, 1, 1, 8'hEE, 8'h00, 4'b0011);
    // fill 0x00..0x17; 0x10.. dropped
    for (int i = 0; i < 24; i++)
      add(0, 1, 0, 8'(i), 8'h00, {i >= 15, i >= 14, 1'b0, i == 0});
    // drain 20 cycles
    for (int j = 0; j < 20; j++)
      add(0, 0, 1, 8'h00, (j < 16) ? 8'(j) : 8'h0F, {1'b0, j == 0, j >= 15, j >= 14});
    // empty + both: write taken, read dropped
    add(0, 1, 1, 8'h40, 8'h0F, 4'b0001);
    for (int k = 1; k < 8; k++) add(0, 1, 0, 8'(8'h40 + k), 8'h0F, 4'b0000);
    // streaming at count 8 across two pointer wraps
    for (int t = 0; t < 40; t++) add(0, 1, 1, 8'(8'h48 + t), 8'(8'h40 + t), 4'b0000);
    // refill to full with 0x70..0x77 (count 9..16)
    for (int k = 0; k < 8; k++) add(0, 1, 0, 8'(8'h70 + k), 8'h67, {k == 7, k >= 6, 2'b00});
    // full + both: read taken, write of 0xFF dropped
    add(0, 1, 1, 8'hFF, 8'h68, 4'b0100);
    for (int j = 0; j < 15; j++)
      add(0, 0, 1, 8'h00, (j < 7) ? 8'(8'h69 + j) : 8'(8'h70 + j - 7), {2'b00, j == 14, j >= 13});
    // 5 items then mid-operation reset
    for (int k = 0; k < 5; k++) add(0, 1, 0, 8'(8'hB0 + k), 8'h77, {3'b000, k == 0});
    add(1, 1, 1, 8'hCC, 8'h00, 4'b0011);
    add(0, 1, 0, 8'hA5, 8'h00, 4'b0001);
    add(0, 0, 1, 8'h00, 8'hA5, 4'b0011);
    add(0, 0, 1, 8'h00, 8'hA5, 4'b0011);
    @(negedge clk);
    foreach (tbl[i]) begin
      reset = tbl[i].rst; wr_en = tbl[i].we; rd_en = tbl[i].re; wr_data = tbl[i].wd;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), rd_data, tbl[i].exp_rd, {full, afull, empty, aempty}, tbl[i].exp_fl);
    end
    // write-to-read latency: empty drops next cycle, data lands one edge after the read accept
    reset = 0; wr_en = 1; rd_en = 0; wr_data = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    check("w2r_after_write", rd_data, 8'hA5, {full, afull, empty, aempty}, 4'b0001);
    wr_en = 0; rd_en = 1;
    @(posedge clk);
    #1;
    check("w2r_read_edge", rd_data, 8'h3C, {full, afull, empty, aempty}, 4'b0011);
    @(negedge clk);
    rd_en = 0;
    @(posedge clk);
    @(negedge clk);
    check("w2r_hold", rd_data, 8'h3C, {full, afull, empty, aempty}, 4'b0011);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
